// File: rtl/snn_in_collector.sv
// snn_in_collector: front-end collector for the Siamese-network input stream.
// Captures one IMG_DEPTH-beat burst (Img every beat, Kernel/Weight on the
// leading beats, Opt on beat 0) into local register files, presents them on
// combinational read ports and holds the frame until the consumer releases it.
// Stream protocol violations (short burst, long burst, overrun) raise a
// sticky err flag with a code. The consumer release input is named
// frame_release because "release" is a reserved word in SystemVerilog.
module snn_in_collector #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IMG_DEPTH = 96,
  parameter int unsigned KER_DEPTH = 27,
  parameter int unsigned WGT_DEPTH = 4,
  parameter int unsigned IMG_AW    = $clog2(IMG_DEPTH),
  parameter int unsigned KER_AW    = $clog2(KER_DEPTH),
  parameter int unsigned WGT_AW    = $clog2(WGT_DEPTH),
  parameter int unsigned CNT_W     = $clog2(IMG_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] Img,
  input  logic [DATA_W-1:0] Kernel,
  input  logic [DATA_W-1:0] Weight,
  input  logic [1:0]        Opt,
  input  logic              frame_release,
  input  logic [IMG_AW-1:0] img_addr,
  input  logic [KER_AW-1:0] ker_addr,
  input  logic [WGT_AW-1:0] wgt_addr,
  output logic [DATA_W-1:0] img_data,
  output logic [DATA_W-1:0] ker_data,
  output logic [DATA_W-1:0] wgt_data,
  output logic [1:0]        opt_q,
  output logic              frame_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_DEPTH - 1);
  localparam logic [KER_AW-1:0] KER_LAST = KER_AW'(KER_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IMG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  KER_LIM  = CNT_W'(KER_DEPTH);
  localparam logic [CNT_W-1:0]  WGT_LIM  = CNT_W'(WGT_DEPTH);

  localparam logic [1:0] ErrShort   = 2'b01;
  localparam logic [1:0] ErrLong    = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StDrain} state_e;

  state_e state_q;
  // High only in the first READY cycle, where a still-running beat means a long burst.
  logic   ready_first_q;
  // Set while an overrun beat train is being ignored in READY.
  logic   ovr_q;

  logic [DATA_W-1:0] mem_img [IMG_DEPTH];
  logic [DATA_W-1:0] mem_ker [KER_DEPTH];
  logic [DATA_W-1:0] mem_wgt [WGT_DEPTH];

  logic             accept_new;
  logic             accept_load;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;

  // Decode which beats are written and at which index.
  always_comb begin
    accept_new  = 1'b0;
    accept_load = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    if (in_valid) begin
      unique case (state_q)
        StIdle:  accept_new = 1'b1;
        StLoad:  accept_load = 1'b1;
        // A new frame may start in READY only via a same-cycle release,
        // never in the cycle right after the last beat or during an overrun.
        StReady: accept_new = frame_release && !ready_first_q && !ovr_q;
        default: ;
      endcase
    end
    wr_en  = rst_n && (accept_new || accept_load);
    wr_idx = accept_load ? beat_cnt : '0;
  end

  // Register files; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_img[wr_idx[IMG_AW-1:0]] <= Img;
      if (wr_idx < KER_LIM) begin
        mem_ker[wr_idx[KER_AW-1:0]] <= Kernel;
      end
      if (wr_idx < WGT_LIM) begin
        mem_wgt[wr_idx[WGT_AW-1:0]] <= Weight;
      end
    end
  end

  // Combinational read ports; out-of-range addresses return zero.
  always_comb begin
    img_data = '0;
    ker_data = '0;
    if (img_addr <= IMG_LAST) begin
      img_data = mem_img[img_addr];
    end
    if (ker_addr <= KER_LAST) begin
      ker_data = mem_ker[ker_addr];
    end
    wgt_data = mem_wgt[wgt_addr];
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ready_first_q <= 1'b0;
      ovr_q         <= 1'b0;
      opt_q         <= '0;
      frame_ready   <= 1'b0;
      busy          <= 1'b0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      err_code      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept_new) begin
            state_q  <= StLoad;
            opt_q    <= Opt;
            beat_cnt <= CNT_W'(1);
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= '0;
          end
        end

        StLoad: begin
          if (accept_load) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_LAST) begin
              state_q       <= StReady;
              busy          <= 1'b0;
              frame_ready   <= 1'b1;
              ready_first_q <= 1'b1;
            end
          end else begin
            // Stream stopped early: drop the partial frame.
            state_q  <= StIdle;
            busy     <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b1;
            err_code <= ErrShort;
          end
        end

        StReady: begin
          ready_first_q <= 1'b0;
          if (ready_first_q && in_valid) begin
            state_q     <= StDrain;
            frame_ready <= 1'b0;
            err         <= 1'b1;
            err_code    <= ErrLong;
          end else if (ovr_q && in_valid) begin
            // Keep ignoring the overrun beat train.
          end else if (accept_new) begin
            // Back-to-back frame: this beat is beat 0 of the next frame.
            state_q     <= StLoad;
            frame_ready <= 1'b0;
            opt_q       <= Opt;
            beat_cnt    <= CNT_W'(1);
            busy        <= 1'b1;
            err         <= 1'b0;
            err_code    <= '0;
          end else if (in_valid) begin
            ovr_q    <= 1'b1;
            err      <= 1'b1;
            err_code <= ErrOverrun;
          end else begin
            ovr_q <= 1'b0;
            if (frame_release) begin
              state_q     <= StIdle;
              frame_ready <= 1'b0;
              beat_cnt    <= '0;
            end
          end
        end

        StDrain: begin
          if (!in_valid) begin
            state_q  <= StIdle;
            beat_cnt <= '0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_in_collector.sv
// Randomized scoreboard bench for snn_in_collector. The stimulus process
// predicts the status events each burst must cause (frame held, or an error
// code) from burst length and timing alone, and queues them; the monitor
// pops one entry whenever frame_ready rises or err/err_code changes, and for
// held frames sweeps every read address against the stored frame contents.
module tb_snn_in_collector;

  localparam int KReady = 0;
  localparam int KErr   = 1;
  localparam int NFR    = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] Img = '0;
  logic [31:0] Kernel = '0;
  logic [31:0] Weight = '0;
  logic [1:0]  Opt = '0;
  logic        frame_release = 1'b0;
  logic [6:0]  img_addr = '0;
  logic [4:0]  ker_addr = '0;
  logic [1:0]  wgt_addr = '0;

  logic [31:0] img_data;
  logic [31:0] ker_data;
  logic [31:0] wgt_data;
  logic [1:0]  opt_q;
  logic        frame_ready;
  logic        busy;
  logic [6:0]  beat_cnt;
  logic        err;
  logic [1:0]  err_code;

  snn_in_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .Img           (Img),
    .Kernel        (Kernel),
    .Weight        (Weight),
    .Opt           (Opt),
    .frame_release (frame_release),
    .img_addr      (img_addr),
    .ker_addr      (ker_addr),
    .wgt_addr      (wgt_addr),
    .img_data      (img_data),
    .ker_data      (ker_data),
    .wgt_data      (wgt_data),
    .opt_q         (opt_q),
    .frame_ready   (frame_ready),
    .busy          (busy),
    .beat_cnt      (beat_cnt),
    .err           (err),
    .err_code      (err_code)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int kind;
    int cyc;
    int code;
    int opt;
    int fr;
    int cnt;
    int fid;
  } exp_t;

  exp_t sb[$];

  // Reference frame contents, one slot per frame expected to be held.
  logic [31:0] fimg [NFR][96];
  logic [31:0] fker [NFR][27];
  logic [31:0] fwgt [NFR][4];
  int nfr = 0;

  task automatic sweep(input int fid);
    for (int a = 0; a < 128; a++) begin
      img_addr = 7'(a);
      #1;
      check($sformatf("img_data@%0d", a), img_data, (a < 96) ? fimg[fid][a] : 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      ker_addr = 5'(a);
      #1;
      check($sformatf("ker_data@%0d", a), ker_data, (a < 27) ? fker[fid][a] : 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      wgt_addr = 2'(a);
      #1;
      check($sformatf("wgt_data@%0d", a), wgt_data, fwgt[fid][a]);
    end
  endtask

  task automatic handle_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      check("event_opt_q", opt_q, e.opt);
      check("event_frame_ready", frame_ready, e.fr);
      check("event_beat_cnt", beat_cnt, e.cnt);
      check("event_busy", busy, 0);
      if (kind == KReady) check("event_err", err, 0);
      else check("event_err_code", err_code, e.code);
      if (e.fid >= 0) sweep(e.fid);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic       fr_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic [1:0] code_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ready && !fr_prev) handle_event(KReady);
      if (err && (!err_prev || err_code != code_prev)) handle_event(KErr);
    end
    fr_prev   = frame_ready;
    err_prev  = err;
    code_prev = err_code;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic rel();
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
  endtask

  task automatic push(input int kind, input int c, input int code, input int opt,
                      input int fr, input int cnt, input int fid);
    exp_t e;
    e.kind = kind; e.cyc = c; e.code = code; e.opt = opt;
    e.fr = fr; e.cnt = cnt; e.fid = fid;
    sb.push_back(e);
  endtask

  // Drive one burst of len beats; beat k is driven in cycle c0+k.
  task automatic send_burst(input int len, input bit pattern, input bit rel_first,
                            input logic [1:0] opt, output int fid);
    int c0;
    c0  = cyc;
    fid = -1;
    if (len >= 96) begin
      fid = nfr;
      nfr++;
      for (int k = 0; k < 96; k++) fimg[fid][k] = pattern ? 32'(k) : $urandom();
      for (int k = 0; k < 27; k++) fker[fid][k] = pattern ? 32'h100 + 32'(k) : $urandom();
      for (int k = 0; k < 4; k++)  fwgt[fid][k] = pattern ? 32'h200 + 32'(k) : $urandom();
      push(KReady, c0 + 96, 0, int'(opt), 1, 96, fid);
      if (len > 96) push(KErr, c0 + 97, 2, int'(opt), 0, 96, -1);
    end else begin
      push(KErr, c0 + len + 1, 1, int'(opt), 0, 0, -1);
    end
    for (int k = 0; k < len; k++) begin
      in_valid      = 1'b1;
      Img           = (fid >= 0 && k < 96) ? fimg[fid][k] : $urandom();
      Kernel        = (fid >= 0 && k < 27) ? fker[fid][k] : $urandom();
      Weight        = (fid >= 0 && k < 4)  ? fwgt[fid][k] : $urandom();
      Opt           = (k == 0) ? opt : 2'($urandom());
      frame_release = (k == 0) && rel_first;
      step();
      frame_release = 1'b0;
      if (k == 0 && rel_first) begin
        check("b2b_frame_ready_drop", frame_ready, 0);
        check("b2b_busy", busy, 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_opt_q"}, opt_q, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_beat_cnt"}, beat_cnt, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  initial begin
    #(100000 * 1000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fid;
    int cp;
    int len;
    int r;
    logic [1:0] o;

    // Reset
    rst_n = 1'b0;
    idle(2);
    check_cleared("reset");
    rst_n = 1'b1;
    idle(2);

    // Nominal patterned frame
    send_burst(96, 1'b1, 1'b0, 2'b10, fid);
    idle(3);
    rel();
    idle(2);
    check("release_frame_ready", frame_ready, 0);

    // Short burst, then a full frame that clears err
    send_burst(50, 1'b0, 1'b0, 2'b01, fid);
    idle(3);
    rel();
    idle(2);
    check("short_frame_ready", frame_ready, 0);
    send_burst(96, 1'b0, 1'b0, 2'b11, fid);
    idle(2);
    check("after_short_err", err, 0);
    rel();
    idle(2);

    // Long burst
    send_burst(98, 1'b0, 1'b0, 2'b01, fid);
    idle(2);
    check("long_busy", busy, 0);
    check("long_frame_ready", frame_ready, 0);
    check("long_beat_cnt", beat_cnt, 0);
    check("long_err", err, 1);
    check("long_err_code", err_code, 2);

    // Back-to-back frames
    send_burst(96, 1'b0, 1'b0, 2'b00, fid);
    idle(3);
    send_burst(96, 1'b0, 1'b1, 2'b11, fid);
    idle(2);
    rel();
    idle(2);

    // Overrun: frame held, stray beats without release
    send_burst(96, 1'b0, 1'b0, 2'b10, fid);
    idle(3);
    cp = cyc;
    push(KErr, cp + 1, 3, 2, 1, 96, fid);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      Img      = $urandom();
      Kernel   = $urandom();
      Weight   = $urandom();
      Opt      = 2'b01;
      step();
    end
    idle(2);
    check("overrun_frame_kept", frame_ready, 1);
    rel();
    idle(1);
    check("overrun_release_frame_ready", frame_ready, 0);
    check("overrun_release_beat_cnt", beat_cnt, 0);

    // Mid-load reset at beat 40
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      Img      = $urandom();
      Kernel   = $urandom();
      Weight   = $urandom();
      Opt      = 2'($urandom());
      step();
    end
    check("midload_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check_cleared("midload_reset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(2);
    send_burst(96, 1'b0, 1'b0, 2'b01, fid);
    idle(2);
    rel();
    idle(2);

    // Randomized bursts
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      if (r < 2) len = 96;
      else if (r == 2) len = int'($urandom_range(1, 95));
      else len = int'($urandom_range(97, 99));
      o = 2'($urandom());
      send_burst(len, 1'b0, 1'b0, o, fid);
      idle(int'($urandom_range(1, 4)));
      rel();
      idle(2);
    end

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
